// File: rtl/mem_arctec_pkg.sv
// rtl/mem_arctec_pkg.sv - shared widths, seed and FSM state type for the memory responder
package mem_arctec_pkg;

  localparam int          MEM_ADDR_W    = 11;
  localparam int          MEM_DATA_W    = 32;
  localparam logic [31:0] MEM_DATA_SEED = 32'hA5A5_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - synchronous request FIFO with combinational head read
module mem_req_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // storage write; entries are not reset, only the pointers and count are
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - L2 refill responder top; define MEM_RESP_STATS_EN for request/stall counters
module mem_responder #(
  parameter int                ADDR_W      = mem_arctec_pkg::MEM_ADDR_W,
  parameter int                DATA_W      = mem_arctec_pkg::MEM_DATA_W,
  parameter int                MEM_LATENCY = 10,
  parameter int                REQ_DEPTH   = 4,
  parameter logic [DATA_W-1:0] DATA_SEED   = DATA_W'(mem_arctec_pkg::MEM_DATA_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0]       stat_req_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);

  import mem_arctec_pkg::*;

  resp_state_t                  state;
  resp_state_t                  state_next;
  logic [7:0]                   cnt;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            data_q;
  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [ADDR_W-1:0]            fifo_head;
  logic [$clog2(REQ_DEPTH):0]   fifo_count;

  // req_ready depends only on the registered FIFO count
  assign req_ready = !fifo_full;

  mem_req_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (req_addr),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state; pop only from IDLE so a handshake is followed by one bubble cycle
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 8'd0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    rsp_valid = (state == RESP);
    busy      = (state != IDLE) || (fifo_count != '0);
  end

  // latency counter and response registers, loaded on pop and held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 8'd0;
      addr_q <= '0;
      data_q <= '0;
    end else if (fifo_pop) begin
      cnt    <= 8'(MEM_LATENCY - 1);
      addr_q <= fifo_head;
      data_q <= DATA_SEED ^ DATA_W'(fifo_head);
    end else if (state == WAIT && cnt != 8'd0) begin
      cnt    <= cnt - 8'd1;
    end
  end

  assign rsp_addr = addr_q;
  assign rsp_data = data_q;

`ifdef MEM_RESP_STATS_EN
  // free-running wrap-around counters of accepted requests and response stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req_cnt   <= 32'd0;
      stat_stall_cnt <= 32'd0;
    end else begin
      if (req_valid && req_ready) begin
        stat_req_cnt <= stat_req_cnt + 32'd1;
      end
      if (rsp_valid && !rsp_ready) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (MEM_RESP_STATS_EN adds stats checks)
module tb_mem_responder;

  localparam int          LAT   = 10;
  localparam int          DEPTH = 4;
  localparam logic [31:0] SEED  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [10:0] rsp_addr;
  logic [31:0] rsp_data;
  logic        busy;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] stat_req_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  mem_responder #(
    .ADDR_W      (11),
    .DATA_W      (32),
    .MEM_LATENCY (LAT),
    .REQ_DEPTH   (DEPTH),
    .DATA_SEED   (SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_addr       (rsp_addr),
    .rsp_data       (rsp_data),
    .busy           (busy)
`ifdef MEM_RESP_STATS_EN
    ,
    .stat_req_cnt   (stat_req_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: every accepted, unanswered address in arrival order; the head is
  // in service from edge m_start and answerable LAT edges later.
  logic [10:0] mq[$];
  bit          m_serving = 1'b0;
  int          m_start   = 0;
  int          edge_n    = 0;
  bit          exp_valid;
  bit          exp_ready;
  bit          exp_busy;

  logic [10:0] got_addr[$];
  int          got_edge[$];

  typedef struct {
    logic [10:0] addr;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_update();
    int occ;
    bit pre_valid;
    bit pre_ready;
    bit do_start;
    edge_n++;
    if (rst) begin
      mq.delete();
      m_serving = 1'b0;
    end else begin
      occ       = mq.size() - (m_serving ? 1 : 0);
      pre_valid = m_serving && ((edge_n - 1) >= m_start + LAT);
      pre_ready = occ < DEPTH;
      do_start  = !m_serving && occ > 0;
      if (pre_valid && rsp_ready) begin
        mq.delete(0);
        m_serving = 1'b0;
      end
      if (do_start) begin
        m_serving = 1'b1;
        m_start   = edge_n;
      end
      if (req_valid && pre_ready) mq.push_back(req_addr);
    end
    exp_valid = m_serving && (edge_n >= m_start + LAT);
    exp_ready = (mq.size() - (m_serving ? 1 : 0)) < DEPTH;
    exp_busy  = mq.size() > 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_valid);
    chk("busy", busy, exp_busy);
    if (exp_valid && mq.size() > 0) begin
      chk("rsp_addr", rsp_addr, mq[0]);
      chk("rsp_data", rsp_data, SEED ^ {21'd0, mq[0]});
    end
  endtask

  task automatic drain(input int n, input int budget);
    got_addr.delete();
    got_edge.delete();
    rsp_ready = 1'b1;
    for (int c = 0; c < budget && got_addr.size() < n; c++) begin
      step();
      if (rsp_valid) begin
        got_addr.push_back(rsp_addr);
        got_edge.push_back(edge_n);
      end
    end
    chk("drain_count", got_addr.size(), n);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!rsp_valid && k < 300) begin
      step();
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int p;

    vecs[0] = '{11'h123, 0, LAT + 1, 32'hA5A5_0123};
    vecs[1] = '{11'h000, 3, LAT + 1, 32'hA5A5_0000};
    vecs[2] = '{11'h7FF, 5, LAT + 1, 32'hA5A5_07FF};
    vecs[3] = '{11'h5A5, 1, LAT + 1, 32'hA5A5_05A5};

    // reset held 3 cycles with a request offered
    rst = 1'b1; req_valid = 1'b1; req_addr = 11'h055; rsp_ready = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0; req_valid = 1'b0;
    step();
    chk("rst_no_push_busy", busy, 0);

    // single-request vectors: latency, data, hold under backpressure
    foreach (vecs[i]) begin
      req_valid = 1'b1; req_addr = vecs[i].addr;
      step();
      req_valid = 1'b0; rsp_ready = 1'b0;
      wait_valid(k);
      chk("vec_latency", k, vecs[i].exp_lat);
      chk("vec_addr", rsp_addr, vecs[i].addr);
      chk("vec_data", rsp_data, vecs[i].exp_data);
      repeat (vecs[i].hold) step();
      chk("vec_hold_valid", rsp_valid, 1);
      chk("vec_hold_data", rsp_data, vecs[i].exp_data);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("vec_after_hs", rsp_valid, 0);
      repeat (2) step();
    end

    // fill: 5 back-to-back with rsp_ready low, 6th stalls until first handshake
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 11'h010 + 11'(i);
      step();
    end
    chk("fill_req_ready", req_ready, 0);
    chk("fill_busy", busy, 1);
    req_addr = 11'h015;
    wait_valid(k);
    chk("fill_stall_ready", req_ready, 0);
    chk("fill_first_addr", rsp_addr, 11'h010);
    rsp_ready = 1'b1;
    step();
    chk("fill_hs_ready", req_ready, 0);
    step();
    chk("fill_pop_ready", req_ready, 1);
    step();
    chk("fill_push_ready", req_ready, 0);
    req_valid = 1'b0;
    drain(5, 200);
    for (int i = 0; i < got_addr.size(); i++) chk("fill_order", got_addr[i], 11'h011 + 11'(i));
    repeat (2) step();

    // order and throughput with rsp_ready held high
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 11'h001 + 11'(i);
      step();
      if (i == 0) p = edge_n;
    end
    req_valid = 1'b0;
    drain(4, 200);
    if (got_edge.size() > 0) chk("thru_first_lat", got_edge[0] - p, LAT + 1);
    for (int i = 0; i < got_addr.size(); i++) chk("thru_order", got_addr[i], 11'h001 + 11'(i));
    for (int i = 1; i < got_edge.size(); i++) chk("thru_spacing", got_edge[i] - got_edge[i-1], LAT + 2);
    repeat (2) step();

    // reset in WAIT with 3 queued, then full latency on a fresh request
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 11'h030 + 11'(i);
      step();
    end
    req_valid = 1'b0;
    repeat (3) step();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = 11'h044;
    step();
    req_valid = 1'b0;
    wait_valid(k);
    chk("mid_new_latency", k, LAT + 1);
    chk("mid_new_addr", rsp_addr, 11'h044);
    rsp_ready = 1'b1;
    step();
    repeat (2) step();

`ifdef MEM_RESP_STATS_EN
    // stats: 3 requests, 7 stalled cycles in RESP
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stat_req_reset", stat_req_cnt, 0);
    chk("stat_stall_reset", stat_stall_cnt, 0);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 11'h060 + 11'(i);
      step();
    end
    req_valid = 1'b0;
    wait_valid(k);
    repeat (7) step();
    drain(2, 200);
    chk("stat_req_cnt", stat_req_cnt, 3);
    chk("stat_stall_cnt", stat_stall_cnt, 7);
    repeat (2) step();
`endif

    // randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom % 2) == 1;
      req_addr  = 11'($urandom);
      rsp_ready = ($urandom % 3) != 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
